// File: rtl/fdiv_arbiter_if.sv
`default_nettype none
// ============================================================================
// fdiv_arbiter_if : requester, divider and response bundle for fdiv_arbiter
// Revision 1.0
// ============================================================================
interface fdiv_arbiter_if #(
   parameter int TAGW = 4
);
   logic            req0_valid;
   logic            req0_ready;
   logic [31:0]     req0_x;
   logic [31:0]     req0_y;
   logic [TAGW-1:0] req0_tag;

   logic            req1_valid;
   logic            req1_ready;
   logic [31:0]     req1_x;
   logic [31:0]     req1_y;
   logic [TAGW-1:0] req1_tag;

   logic            flush;

   logic [31:0]     div_x;
   logic [31:0]     div_y;
   logic [31:0]     div_res;

   logic            rsp0_valid;
   logic [31:0]     rsp0_res;
   logic [TAGW-1:0] rsp0_tag;
   logic            rsp1_valid;
   logic [31:0]     rsp1_res;
   logic [TAGW-1:0] rsp1_tag;

   logic [3:0]      inflight;
   logic            idle;

   // Environment side: requesters plus the shared divider.
   modport master (
      output req0_valid, req0_x, req0_y, req0_tag,
      output req1_valid, req1_x, req1_y, req1_tag,
      output flush, div_res,
      input  req0_ready, req1_ready, div_x, div_y,
      input  rsp0_valid, rsp0_res, rsp0_tag,
      input  rsp1_valid, rsp1_res, rsp1_tag,
      input  inflight, idle
   );

   modport slave (
      input  req0_valid, req0_x, req0_y, req0_tag,
      input  req1_valid, req1_x, req1_y, req1_tag,
      input  flush, div_res,
      output req0_ready, req1_ready, div_x, div_y,
      output rsp0_valid, rsp0_res, rsp0_tag,
      output rsp1_valid, rsp1_res, rsp1_tag,
      output inflight, idle
   );
endinterface
`default_nettype wire

// File: rtl/fdiv_arbiter.sv
`default_nettype none
// ============================================================================
// fdiv_arbiter : two-requester round-robin front end for a pipelined divider
// Revision 1.0
// ============================================================================
module fdiv_arbiter #(
   parameter int LATENCY = 3,
   parameter int TAGW    = 4
) (
   input  logic           clk,
   input  logic           rstn,
   fdiv_arbiter_if.slave  bus
);

   logic                ptr;
   logic                grant0;
   logic                grant1;
   logic                accept;
   logic                retire;

   logic [LATENCY:0]    stg_valid;
   logic [LATENCY:0]    stg_id;
   logic [TAGW-1:0]     stg_tag [LATENCY+1];

   logic [31:0]         div_x_q;
   logic [31:0]         div_y_q;
   logic                rsp0_valid_q;
   logic                rsp1_valid_q;
   logic [31:0]         rsp0_res_q;
   logic [31:0]         rsp1_res_q;
   logic [TAGW-1:0]     rsp0_tag_q;
   logic [TAGW-1:0]     rsp1_tag_q;
   logic [3:0]          inflight_q;

   // Ready is gated by rstn so nothing looks accepted while in reset.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (rstn && !bus.flush) begin
         if (bus.req0_valid && (!bus.req1_valid || !ptr)) begin
            grant0 = 1'b1;
         end else if (bus.req1_valid) begin
            grant1 = 1'b1;
         end
      end
   end

   assign accept = grant0 | grant1;
   assign retire = stg_valid[LATENCY] & ~bus.flush;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ptr     <= 1'b0;
         div_x_q <= 32'h0;
         div_y_q <= 32'h0;
      end else if (accept) begin
         ptr     <= grant0;
         div_x_q <= grant1 ? bus.req1_x : bus.req0_x;
         div_y_q <= grant1 ? bus.req1_y : bus.req0_y;
      end
   end

   // Tracking pipe: stage LATENCY lines up with div_res for that operation.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stg_valid <= '0;
         stg_id    <= '0;
         for (int i = 0; i <= LATENCY; i++) begin
            stg_tag[i] <= '0;
         end
      end else begin
         stg_valid  <= bus.flush ? '0 : {stg_valid[LATENCY-1:0], accept};
         stg_id     <= {stg_id[LATENCY-1:0], grant1};
         stg_tag[0] <= grant1 ? bus.req1_tag : bus.req0_tag;
         for (int i = 1; i <= LATENCY; i++) begin
            stg_tag[i] <= stg_tag[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_res_q   <= 32'h0;
         rsp1_res_q   <= 32'h0;
         rsp0_tag_q   <= '0;
         rsp1_tag_q   <= '0;
      end else begin
         rsp0_valid_q <= retire & ~stg_id[LATENCY];
         rsp1_valid_q <= retire &  stg_id[LATENCY];
         if (retire && !stg_id[LATENCY]) begin
            rsp0_res_q <= bus.div_res;
            rsp0_tag_q <= stg_tag[LATENCY];
         end
         if (retire && stg_id[LATENCY]) begin
            rsp1_res_q <= bus.div_res;
            rsp1_tag_q <= stg_tag[LATENCY];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         inflight_q <= 4'd0;
      end else if (bus.flush) begin
         inflight_q <= 4'd0;
      end else if (accept && !retire) begin
         inflight_q <= inflight_q + 4'd1;
      end else if (retire && !accept) begin
         inflight_q <= inflight_q - 4'd1;
      end
   end

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;
   assign bus.div_x      = div_x_q;
   assign bus.div_y      = div_y_q;
   assign bus.rsp0_valid = rsp0_valid_q;
   assign bus.rsp1_valid = rsp1_valid_q;
   assign bus.rsp0_res   = rsp0_res_q;
   assign bus.rsp1_res   = rsp1_res_q;
   assign bus.rsp0_tag   = rsp0_tag_q;
   assign bus.rsp1_tag   = rsp1_tag_q;
   assign bus.inflight   = inflight_q;
   assign bus.idle       = (inflight_q == 4'd0) && !rsp0_valid_q && !rsp1_valid_q;

endmodule
`default_nettype wire

// File: doc/fdiv_arbiter.md
FDIV_ARBITER -- requirements
Module: fdiv_arbiter

Interface
REQ-001 The block SHALL have parameter LATENCY, default 3, giving the number of clock edges from a change on div_x/div_y to the matching value on div_res of the attached pipelined divider.
REQ-002 The block SHALL have parameter TAGW, default 4, giving the width of the requester transaction tag.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rstn  input  1  asynchronous active-low reset.
REQ-005 reqN_valid  input  1  (N=0,1) requester N presents an operand pair.
REQ-006 reqN_ready  output  1  (N=0,1) requester N's pair is accepted this cycle.
REQ-007 reqN_x, reqN_y  input  32  (N=0,1) IEEE-754 single dividend and divisor.
REQ-008 reqN_tag  input  TAGW  (N=0,1) opaque tag returned with the result.
REQ-009 flush  input  1  synchronous kill of all in-flight operations.
REQ-010 div_x, div_y  output  32  registered operands driven to the shared divider.
REQ-011 div_res  input  32  divider result, valid LATENCY edges after operands are driven.
REQ-012 rspN_valid  output  1  (N=0,1) one-cycle result pulse for requester N.
REQ-013 rspN_res  output  32  (N=0,1) quotient.
REQ-014 rspN_tag  output  TAGW  (N=0,1) tag of the completed operation.
REQ-015 inflight  output  4  number of accepted, not yet responded, unflushed operations.
REQ-016 idle  output  1  high when inflight==0 and no rspN_valid is asserted.

Function
REQ-017 Arbitration SHALL be round-robin with a 1-bit priority pointer: with both valid, the pointed requester is granted; with one valid, it is granted regardless of the pointer.
REQ-018 After every grant, the pointer SHALL move to the non-granted requester; it SHALL be unchanged in cycles with no grant.
REQ-019 At most one request SHALL be granted per cycle; reqN_ready SHALL be combinational from the valids, pointer and flush, and SHALL be 0 when flush=1.
REQ-020 The block SHALL accept a new operation every cycle (full throughput); there is no backpressure from the response side.
REQ-021 On an accepting edge, div_x/div_y SHALL load the granted operands; with no grant they SHALL hold their previous values.
REQ-022 A LATENCY+1-deep shift register SHALL carry {valid, requester id, tag} alongside each operation; stage 0 loads on the accepting edge.
REQ-023 On the edge where the tracked entry reaches the end of the shift register, the block SHALL register div_res into rspN_res, the tag into rspN_tag, and pulse rspN_valid for exactly one cycle for the owning requester only; the other rsp port's valid SHALL be 0.
REQ-024 Response latency SHALL be exactly LATENCY+1 edges from the accepting edge to the edge that raises rspN_valid; results SHALL return in issue order.
REQ-025 rspN_res/rspN_tag SHALL hold their last values while rspN_valid=0.
REQ-026 inflight SHALL increment on accept, decrement on response, and be unchanged when both occur on the same edge; it SHALL never exceed LATENCY+1.
REQ-027 flush=1 SHALL clear all shift-register valid bits and inflight on that edge and suppress any rspN_valid that would have been raised on that edge; no operation is accepted that cycle.
REQ-028 The arbiter SHALL NOT inspect or alter operand or result values (no exception handling in this block).

Reset
REQ-029 While rstn=0: reqN_ready=0, rspN_valid=0, rspN_res=0, rspN_tag=0, div_x=0, div_y=0, inflight=0, idle=1, pointer=requester 0, all shift-register valid bits 0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight operations; no response for them SHALL ever be produced after rstn returns to 1.
REQ-031 The first edge after rstn deassertion SHALL be able to accept a request.

Verification
REQ-032 Single op: LATENCY=3, req0 x=0x40C00000 (6.0), y=0x40000000 (2.0), tag=5 -> rsp0_valid one pulse 4 edges later, rsp0_res=0x40400000, rsp0_tag=5, rsp1_valid=0.
REQ-033 Contention: both valid continuously for 6 cycles, pointer at 0 -> grants alternate 0,1,0,1,0,1; responses return in that order, one per cycle, inflight peaks at 4.
REQ-034 One-sided stream: req1 valid 8 consecutive cycles, req0 idle -> req1 granted every cycle, tags 0..7 returned in order back-to-back.
REQ-035 Flush: 3 ops in flight, flush pulsed one cycle -> no rsp pulses for them, inflight=0, idle=1 next cycle; a request issued after flush returns normally.
REQ-036 Reset mid-flight: 2 ops accepted, rstn low one cycle -> all outputs at reset values, no later responses, inflight=0.
REQ-037 Simultaneous accept and respond at steady state -> inflight unchanged across the edge.
